// File: rtl/qpu_mcu_measure_collect_pkg.sv
// qpu_mcu_measure_collect_pkg: shared sizing defaults and FSM state type for measurement collection.
package qpu_mcu_measure_collect_pkg;
    localparam int QPU_QUBIT_NUM = 4;
    localparam int TOUT_W_DEF = 16;
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMMIT} state_t;
endpackage

// File: rtl/qpu_mcu_measure_collect.sv
// qpu_mcu_measure_collect: gathers per-qubit readout results for one batch and commits them once, on completion or timeout.
module qpu_mcu_measure_collect
    import qpu_mcu_measure_collect_pkg::*;
#(
    parameter int QUBIT_NUM = QPU_QUBIT_NUM,
    parameter int TOUT_W = TOUT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 meas_start_i,
    input  logic [QUBIT_NUM-1:0] meas_list_i,
    output logic                 meas_ready_o,
    input  logic [QUBIT_NUM-1:0] rd_valid_i,
    input  logic [QUBIT_NUM-1:0] rd_data_i,
    input  logic [TOUT_W-1:0]    tout_cfg_i,
    output logic                 mcu_measure_o_wen,
    output logic [QUBIT_NUM-1:0] mcu_measure_o_data,
    output logic [QUBIT_NUM-1:0] mcu_measure_o_list,
    output logic                 meas_tout_o,
    output logic                 busy_o
);
    state_t               state;
    logic [QUBIT_NUM-1:0] list_r, pend_r, data_r, hit, pend_nx, data_nx;
    logic [TOUT_W-1:0]    cnt_r;
    logic                 tout_hit;

    // Only still-pending qubits are captured, so the first result for a qubit wins.
    always_comb begin
        hit      = rd_valid_i & pend_r;
        pend_nx  = pend_r & ~hit;
        data_nx  = (data_r & ~hit) | (rd_data_i & hit);
        tout_hit = (tout_cfg_i != '0) && (cnt_r == tout_cfg_i - TOUT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            list_r             <= '0;
            pend_r             <= '0;
            data_r             <= '0;
            cnt_r              <= '0;
            meas_ready_o       <= 1'b1;
            busy_o             <= 1'b0;
            mcu_measure_o_wen  <= 1'b0;
            mcu_measure_o_data <= '0;
            mcu_measure_o_list <= '0;
            meas_tout_o        <= 1'b0;
        end else begin
            mcu_measure_o_wen <= 1'b0;
            meas_tout_o       <= 1'b0;
            case (state)
                S_IDLE: if (meas_start_i && |meas_list_i) begin
                    list_r       <= meas_list_i;
                    pend_r       <= meas_list_i;
                    data_r       <= '0;
                    cnt_r        <= '0;
                    meas_ready_o <= 1'b0;
                    busy_o       <= 1'b1;
                    state        <= S_COLLECT;
                end
                S_COLLECT: begin
                    pend_r <= pend_nx;
                    data_r <= data_nx;
                    cnt_r  <= &cnt_r ? cnt_r : cnt_r + TOUT_W'(1);
                    // Completion takes priority: a timeout is flagged only if qubits remain pending.
                    if (pend_nx == '0 || tout_hit) begin
                        state              <= S_COMMIT;
                        mcu_measure_o_wen  <= 1'b1;
                        mcu_measure_o_data <= data_nx;
                        mcu_measure_o_list <= list_r;
                        meas_tout_o        <= |pend_nx;
                    end
                end
                S_COMMIT: begin
                    state        <= S_IDLE;
                    meas_ready_o <= 1'b1;
                    busy_o       <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qpu_mcu_measure_collect.sv
// tb_qpu_mcu_measure_collect: randomized and directed checks of batch collection against an arrival-time model.
module tb_qpu_mcu_measure_collect;
    localparam int Q = 4;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          meas_start_i = 1'b0;
    logic [Q-1:0]  meas_list_i = '0;
    logic [Q-1:0]  rd_valid_i = '0;
    logic [Q-1:0]  rd_data_i = '0;
    logic [TW-1:0] tout_cfg_i = 16'd8;
    logic          meas_ready_o, wen, tout, busy;
    logic [Q-1:0]  odata, olist;
    int            total = 0;
    int            passed = 0;

    always #5 clk = ~clk;

    qpu_mcu_measure_collect #(.QUBIT_NUM(Q), .TOUT_W(TW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .meas_start_i(meas_start_i),
        .meas_list_i(meas_list_i),
        .meas_ready_o(meas_ready_o),
        .rd_valid_i(rd_valid_i),
        .rd_data_i(rd_data_i),
        .tout_cfg_i(tout_cfg_i),
        .mcu_measure_o_wen(wen),
        .mcu_measure_o_data(odata),
        .mcu_measure_o_list(olist),
        .meas_tout_o(tout),
        .busy_o(busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        meas_start_i = 1'b0;
        meas_list_i  = '0;
        rd_valid_i   = '0;
        rd_data_i    = '0;
    endtask

    // arr[q] is the cycle (relative to the start cycle 0) of qubit q's first result; 0 means it never reports.
    task automatic run_batch(input string nm, input logic [3:0] list, input int arr[4],
                             input logic [3:0] dat, input logic [15:0] tcfg);
        int         m = 0;
        int         ec;
        bit         all_in = 1'b1;
        logic [3:0] ed = '0;
        logic       et;
        for (int q = 0; q < 4; q++)
            if (list[q]) begin
                if (arr[q] == 0) all_in = 1'b0;
                else if (arr[q] > m) m = arr[q];
            end
        if (all_in && (tcfg == 0 || m <= int'(tcfg))) begin
            ec = m + 1;
            et = 1'b0;
            ed = dat & list;
        end else begin
            ec = int'(tcfg) + 1;
            et = 1'b1;
            for (int q = 0; q < 4; q++)
                if (list[q] && arr[q] != 0 && arr[q] <= int'(tcfg)) ed[q] = dat[q];
        end
        tout_cfg_i = tcfg;
        for (int c = 0; c < ec; c++) begin
            meas_start_i = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            meas_list_i  = (c == 0) ? list : 4'($urandom);
            rd_valid_i   = '0;
            rd_data_i    = 4'($urandom);
            for (int q = 0; q < 4; q++) begin
                if (c == 0 || !list[q]) rd_valid_i[q] = 1'($urandom_range(0, 1));
                else if (arr[q] == c) begin
                    rd_valid_i[q] = 1'b1;
                    rd_data_i[q]  = dat[q];
                end else if (arr[q] != 0 && c > arr[q]) rd_valid_i[q] = 1'($urandom_range(0, 1));
            end
            step;
            total++;
            if (c + 1 < ec) begin
                if (wen !== 1'b0 || busy !== 1'b1 || meas_ready_o !== 1'b0)
                    $display("FAIL %s collect c=%0d: wen=%b busy=%b ready=%b, want wen=0 busy=1 ready=0",
                             nm, c + 1, wen, busy, meas_ready_o);
                else passed++;
            end else begin
                if ({wen, tout, olist, odata} !== {1'b1, et, list, ed})
                    $display("FAIL %s commit c=%0d: wen=%b tout=%b list=%b data=%b, want 1 %b %b %b",
                             nm, c + 1, wen, tout, olist, odata, et, list, ed);
                else passed++;
            end
        end
        // Start offered while in COMMIT must be refused; outputs hold afterwards.
        meas_start_i = 1'b1;
        meas_list_i  = 4'hF;
        rd_valid_i   = 4'($urandom);
        step;
        total++;
        if ({wen, tout, meas_ready_o, busy, olist, odata} !== {1'b0, 1'b0, 1'b1, 1'b0, list, ed})
            $display("FAIL %s post-commit: wen=%b tout=%b ready=%b busy=%b list=%b data=%b, want 0 0 1 0 %b %b",
                     nm, wen, tout, meas_ready_o, busy, olist, odata, list, ed);
        else passed++;
        idle_in;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step;
        step;
        total++;
        if ({meas_ready_o, busy, wen, tout, olist, odata} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0})
            $display("FAIL reset: ready=%b busy=%b wen=%b tout=%b list=%b data=%b, want 1 0 0 0 0000 0000",
                     meas_ready_o, busy, wen, tout, olist, odata);
        else passed++;
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_directed;
        run_batch("req037", 4'b0101, '{2, 0, 4, 0}, 4'b0001, 16'd8);
        run_batch("req038", 4'b1111, '{1, 1, 1, 1}, 4'b1010, 16'd8);
        run_batch("req039", 4'b0011, '{3, 0, 0, 0}, 4'b0001, 16'd8);
        run_batch("tie", 4'b0110, '{0, 5, 3, 0}, 4'b0110, 16'd5);
        run_batch("tout1", 4'b1001, '{0, 0, 0, 1}, 4'b1000, 16'd1);
    endtask

    task automatic test_zero_list;
        meas_start_i = 1'b1;
        meas_list_i  = 4'b0000;
        rd_valid_i   = 4'b1111;
        step;
        idle_in;
        step;
        total++;
        if (meas_ready_o !== 1'b1 || busy !== 1'b0 || wen !== 1'b0)
            $display("FAIL zero_list: ready=%b busy=%b wen=%b, want 1 0 0", meas_ready_o, busy, wen);
        else passed++;
    endtask

    task automatic test_reset_mid;
        bit seen = 1'b0;
        tout_cfg_i   = '0;
        meas_start_i = 1'b1;
        meas_list_i  = 4'b0011;
        step;
        idle_in;
        rd_valid_i = 4'b0001;
        rd_data_i  = 4'b0001;
        step;
        idle_in;
        for (int i = 0; i < 40; i++) begin
            step;
            if (wen !== 1'b0 || busy !== 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) $display("FAIL tout0_hold: wen or busy changed, want wen=0 busy=1 for 40 cycles");
        else passed++;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        total++;
        if (wen !== 1'b0 || meas_ready_o !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_mid: wen=%b ready=%b busy=%b, want 0 1 0", wen, meas_ready_o, busy);
        else passed++;
        rd_valid_i = 4'b1111;
        rd_data_i  = 4'b1111;
        step;
        idle_in;
        step;
        total++;
        if (wen !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_mid_idle: wen=%b busy=%b, want 0 0", wen, busy);
        else passed++;
        run_batch("req042", 4'b1000, '{0, 0, 0, 2}, 4'b1000, 16'd8);
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  list = 4'($urandom_range(1, 15));
            logic [15:0] tcfg = 16'($urandom_range(0, 12));
            logic [3:0]  dat = 4'($urandom);
            int          arr[4];
            for (int q = 0; q < 4; q++) begin
                arr[q] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12));
                if (tcfg == 0 && arr[q] == 0) arr[q] = int'($urandom_range(1, 12));
            end
            run_batch("random", list, arr, dat, tcfg);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_zero_list;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
